// File: rtl/sw_debounce.sv
// Switch conditioning: 2-flop sync, per-channel debounce FSM, registered edge pulses.
// Optional sticky press flags are built when SW_DEBOUNCE_EVENT_EN is defined.
module sw_debounce #(
  parameter int NumSw          = 13,
  parameter int DebounceCycles = 30000
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [NumSw-1:0] sw_n_i,
  output logic [NumSw-1:0] sw_o,
  output logic [NumSw-1:0] rise_o,
  output logic [NumSw-1:0] fall_o,
  output logic [NumSw-1:0] event_o,
  input  logic [NumSw-1:0] clear_i
);

  localparam int              CntW      = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast   = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam bit              Immediate = (DebounceCycles == 1);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_e;

  logic [NumSw-1:0] sync1_q;
  logic [NumSw-1:0] sync2_q;
  logic [NumSw-1:0] s;

  // Pads idle high (pull-ups), so the synchroniser resets to "released".
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sw_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  for (genvar i = 0; i < NumSw; i++) begin : g_ch
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            sw_q;
    logic            rise_q;
    logic            fall_q;

    always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        sw_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state_q)
          STABLE: begin
            if (s[i] == sw_q) begin
              cnt_q <= '0;
            end else if (Immediate) begin
              sw_q   <= s[i];
              rise_q <= s[i];
              fall_q <= ~s[i];
              cnt_q  <= '0;
            end else begin
              state_q <= COUNTING;
              cnt_q   <= CntOne;
            end
          end
          COUNTING: begin
            if (s[i] == sw_q) begin
              // Bounced back before the level was trusted.
              state_q <= STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == CntLast) begin
              sw_q    <= s[i];
              rise_q  <= s[i];
              fall_q  <= ~s[i];
              cnt_q   <= '0;
              state_q <= STABLE;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          default: begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign sw_o[i]   = sw_q;
    assign rise_o[i] = rise_q;
    assign fall_o[i] = fall_q;
  end

`ifdef SW_DEBOUNCE_EVENT_EN
  logic [NumSw-1:0] event_q;

  // Set wins over a same-cycle clear.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      event_q <= '0;
    end else begin
      event_q <= rise_o | (event_q & ~clear_i);
    end
  end

  assign event_o = event_q;
`else
  logic unused_clear;
  assign unused_clear = ^clear_i;
  assign event_o      = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed vector table, mid-count reset sequence, and
// random toggling checked each cycle against a sliding-window reference model.
module tb_sw_debounce;

  localparam int N = 13;
  localparam int D = 4;
  localparam logic [N-1:0] ALL = 13'h1FFF;
`ifdef SW_DEBOUNCE_EVENT_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sw_n;
  logic [N-1:0] clr;
  logic [N-1:0] sw;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] ev;

  int n_tests = 0;
  int n_fail  = 0;

  sw_debounce #(.NumSw(N), .DebounceCycles(D)) dut (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .sw_n_i    (sw_n),
    .sw_o      (sw),
    .rise_o    (rise),
    .fall_o    (fall),
    .event_o   (ev),
    .clear_i   (clr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: an accepted level is one the synchronised input has shown,
  // different from the current output, for the last D consecutive edges.
  logic [N-1:0] m_sync1, m_sync2, m_sw, m_rise, m_fall, m_ev;
  logic [D-1:0] m_hist [N];
  logic [4*N-1:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sync1 = ALL;
      m_sync2 = ALL;
      m_sw    = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_ev    = '0;
      for (int i = 0; i < N; i++) m_hist[i] = '0;
    end else begin
      m_ev = m_rise | (m_ev & ~clr);
      for (int i = 0; i < N; i++) begin
        logic acc;
        m_hist[i] = {m_hist[i][D-2:0], ~m_sync2[i]};
        acc = (m_hist[i] == {D{~m_sw[i]}});
        m_rise[i] = acc & ~m_sw[i];
        m_fall[i] = acc & m_sw[i];
        if (acc) m_sw[i] = ~m_sw[i];
      end
      m_sync2 = m_sync1;
      m_sync1 = sw_n;
    end
    exp_q.push_back({m_sw, m_rise, m_fall, EV_EN ? m_ev : {N{1'b0}}});
  end

  // scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4*N-1:0] e;
      e = exp_q.pop_front();
      chk("model_sw",   sw,   e[4*N-1:3*N]);
      chk("model_rise", rise, e[3*N-1:2*N]);
      chk("model_fall", fall, e[2*N-1:N]);
      chk("model_ev",   ev,   e[N-1:0]);
      chk("rise_fall_excl", rise & fall, '0);
    end
  end

  typedef struct {
    logic         rst_n;
    logic [N-1:0] sw_n;
    logic [N-1:0] clr;
    int           hold;
    logic [N-1:0] e_sw;
    logic [N-1:0] e_rise;
    logic [N-1:0] e_fall;
    logic [N-1:0] e_ev;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [N-1:0] s_n, input logic [N-1:0] c,
                     input int h, input logic [N-1:0] es, input logic [N-1:0] er,
                     input logic [N-1:0] ef, input logic [N-1:0] ee);
    vec_t v;
    v.rst_n = r; v.sw_n = s_n; v.clr = c; v.hold = h;
    v.e_sw = es; v.e_rise = er; v.e_fall = ef; v.e_ev = ee;
    tbl.push_back(v);
  endtask

  // driver: inputs change on the falling edge, sampled at the next rising edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw_n  = '0;
    clr   = '0;

    //  rst   sw_n     clr  hold  sw      rise    fall    event
    add(1'b0, 13'h0000, '0,   3, '0,      '0,     '0,     '0);      // reset, all held pressed
    add(1'b1, 13'h0000, '0,   5, '0,      '0,     '0,     '0);
    add(1'b1, 13'h0000, '0,   1, ALL,     ALL,    '0,     '0);      // 6 edges after release
    add(1'b1, 13'h0000, '0,   1, ALL,     '0,     '0,     ALL);
    add(1'b1, ALL,      ALL,  6, '0,      '0,     ALL,    '0);      // release all
    add(1'b1, ALL,      '0,   1, '0,      '0,     '0,     '0);
    add(1'b1, 13'h1FF7, '0,   5, '0,      '0,     '0,     '0);      // clean press ch3
    add(1'b1, 13'h1FF7, '0,   1, 13'h008, 13'h008, '0,    '0);
    add(1'b1, 13'h1FF7, '0,   1, 13'h008, '0,     '0,     13'h008);
    add(1'b1, 13'h1FF6, '0,   3, 13'h008, '0,     '0,     13'h008); // 3-cycle glitch ch0
    add(1'b1, 13'h1FF7, '0,   6, 13'h008, '0,     '0,     13'h008);
    add(1'b1, 13'h1FF6, '0,   6, 13'h009, 13'h001, '0,    13'h008); // held press ch0
    add(1'b1, 13'h1FF6, '0,   1, 13'h009, '0,     '0,     13'h009);
    add(1'b1, 13'h1FD6, '0,   7, 13'h029, '0,     '0,     13'h029); // press ch5
    add(1'b1, 13'h1FF6, '0,   6, 13'h009, '0,     13'h020, 13'h029); // release ch5
    add(1'b1, 13'h1FF6, '0,   1, 13'h009, '0,     '0,     13'h029);
    add(1'b1, ALL,      '0,   7, '0,      '0,     '0,     13'h029);
    add(1'b1, 13'h0000, '0,   6, ALL,     ALL,    '0,     13'h029); // all channels together
    add(1'b1, 13'h0000, '0,   1, ALL,     '0,     '0,     ALL);
    add(1'b1, 13'h0000, ALL,  1, ALL,     '0,     '0,     '0);
    add(1'b1, 13'h0004, '0,   7, 13'h1FFB, '0,    '0,     '0);      // ch2 sticky event
    add(1'b1, 13'h0000, '0,   7, ALL,     '0,     '0,     13'h004);
    add(1'b1, 13'h0004, '0,   7, 13'h1FFB, '0,    '0,     13'h004);
    add(1'b1, 13'h0000, '0,   6, ALL,     13'h004, '0,    13'h004);
    add(1'b1, 13'h0000, 13'h004, 1, ALL,  '0,     '0,     13'h004); // clear with rise: set wins
    add(1'b1, 13'h0000, 13'h004, 1, ALL,  '0,     '0,     '0);      // clear alone
    add(1'b1, 13'h0000, '0,   1, ALL,     '0,     '0,     '0);

    @(negedge clk);
    foreach (tbl[k]) begin
      rst_n = tbl[k].rst_n;
      sw_n  = tbl[k].sw_n;
      clr   = tbl[k].clr;
      cycles(tbl[k].hold);
      chk($sformatf("vec%0d_sw", k),   sw,   tbl[k].e_sw);
      chk($sformatf("vec%0d_rise", k), rise, tbl[k].e_rise);
      chk($sformatf("vec%0d_fall", k), fall, tbl[k].e_fall);
      chk($sformatf("vec%0d_ev", k),   ev,   EV_EN ? tbl[k].e_ev : {N{1'b0}});
    end

    // Reset while ch4 is mid-count; the still-pressed channels re-accept afterwards.
    clr  = '0;
    sw_n = 13'h0010;
    cycles(3);
    rst_n = 1'b0;
    cycles(1);
    chk("midrst_sw",   sw,   '0);
    chk("midrst_rise", rise, '0);
    chk("midrst_fall", fall, '0);
    chk("midrst_ev",   ev,   '0);
    rst_n = 1'b1;
    cycles(5);
    chk("rerel_sw_early", sw, '0);
    cycles(1);
    chk("rerel_sw",   sw,   13'h1FEF);
    chk("rerel_rise", rise, 13'h1FEF);
    cycles(1);
    chk("rerel_rise_off", rise, '0);

    // random toggling with short and long holds, occasional clear and reset
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] flip;
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 9) == 0);
      sw_n  = sw_n ^ flip;
      clr   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      rst_n = ($urandom_range(0, 299) != 0);
      cycles(1);
    end
    rst_n = 1'b1;
    clr   = '0;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
